// File: rtl/triangle_source_arbiter.sv
// triangle_source_arbiter
//   Shares one transform/frustum-cull triangle pipeline among NUM_SOURCES
//   mesh streams. Ownership is granted round-robin per mesh: a granted source
//   keeps the pipeline until its src_last triangle handshakes. End-of-frame
//   flushes block new grants, wait for the downstream stages to drain, then
//   pulse flush_done and publish the frame's triangle count.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   src_triangle      per-source triangle (DATA_W bits each)
//   src_valid         per-source valid
//   src_last          per-source last-triangle-of-mesh marker
//   src_ready         per-source ready (only the owner may see ready)
//   out_triangle      triangle toward the transformer/culler
//   out_valid         downstream valid
//   out_ready         downstream ready
//   downstream_busy   OR of busy flags of the stages behind this block
//   grant_id          current owner index (meaningful while locked)
//   locked            a source currently owns the pipeline
//   flush_req         single-cycle end-of-frame request
//   flush_done        single-cycle pulse once the frame has drained
//   frame_tri_count   triangles accepted in the last completed frame
module triangle_source_arbiter #(
  parameter int NUM_SOURCES = 4,
  parameter int CNT_W       = 24,
  parameter int DATA_W      = 96,
  localparam int GW         = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_SOURCES-1:0][DATA_W-1:0]   src_triangle,
  input  logic [NUM_SOURCES-1:0]               src_valid,
  input  logic [NUM_SOURCES-1:0]               src_last,
  output logic [NUM_SOURCES-1:0]               src_ready,
  output logic [DATA_W-1:0]                    out_triangle,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  input  logic                                 downstream_busy,
  output logic [GW-1:0]                        grant_id,
  output logic                                 locked,
  input  logic                                 flush_req,
  output logic                                 flush_done,
  output logic [CNT_W-1:0]                     frame_tri_count
);

  typedef enum logic [1:0] {IDLE, LOCKED, DRAIN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [GW-1:0]    last_grant;
  logic             flush_pending;
  logic [CNT_W-1:0] tri_cnt;
  logic             hs;
  logic             hs_last;

  // Round-robin pick: first requester strictly after 'last', wrapping.
  // Walking the distance downward lets the nearest candidate win.
  function automatic logic [GW-1:0] next_grant(input logic [NUM_SOURCES-1:0] req,
                                               input logic [GW-1:0]          last);
    logic [GW-1:0] pick;
    int            cand;
    pick = last;
    for (int k = NUM_SOURCES; k >= 1; k--) begin
      cand = (int'(last) + k) % NUM_SOURCES;
      if (req[cand]) pick = GW'(cand);
    end
    return pick;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    state_nxt    = state;
    src_ready    = '0;
    out_valid    = 1'b0;
    out_triangle = '0;
    hs           = 1'b0;
    hs_last      = 1'b0;
    unique case (state)
      IDLE: begin
        if (flush_pending)   state_nxt = DRAIN;
        else if (|src_valid) state_nxt = LOCKED;
      end
      LOCKED: begin
        out_valid           = src_valid[grant_id];
        out_triangle        = src_triangle[grant_id];
        src_ready[grant_id] = out_ready;
        hs                  = src_valid[grant_id] && out_ready;
        hs_last             = hs && src_last[grant_id];
        if (hs_last) state_nxt = IDLE;
      end
      DRAIN: begin
        if (!downstream_busy) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign locked     = (state == LOCKED);
  assign flush_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      grant_id        <= '0;
      last_grant      <= GW'(NUM_SOURCES - 1);
      flush_pending   <= 1'b0;
      tri_cnt         <= '0;
      frame_tri_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && !flush_pending && |src_valid)
        grant_id <= next_grant(src_valid, last_grant);
      if (hs)      tri_cnt    <= sat_inc(tri_cnt);
      if (hs_last) last_grant <= grant_id;
      if (state == DONE) begin
        frame_tri_count <= tri_cnt;
        tri_cnt         <= '0;
        flush_pending   <= 1'b0;
      end
      // A request landing on the DONE cycle must survive the clear.
      if (flush_req) flush_pending <= 1'b1;
    end
  end

endmodule
